// File: rtl/syx_dump_reader.sv
// syx_dump_reader: walks every parameter bank and streams one framed SysEx dump message per bank.
// Define SYX_DUMP_CHECKSUM_EN to insert a 7-bit checksum byte ahead of each F7.
module syx_dump_reader #(
    parameter int         NUM_BANKS  = 5,
    parameter int         BANK_DEPTH = 64,
    parameter int         ADR_W      = 7,
    parameter int         RD_LAT     = 2,
    parameter logic [7:0] MFR_ID     = 8'h7D
) (
    input  logic             CLOCK_25,
    input  logic             iRST,
    input  logic             dump_req,
    output logic [2:0]       bank_adr,
    output logic [4:0]       sel,
    output logic [ADR_W-1:0] adr,
    output logic             rd_en,
    input  logic [7:0]       rd_data,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);
    typedef enum logic [3:0] {
        IDLE, SOX, MFR, BANK, RD_ISSUE, RD_WAIT, DATA,
`ifdef SYX_DUMP_CHECKSUM_EN
        CKS,
`endif
        EOX, NEXT
    } state_t;

    localparam logic [ADR_W-1:0] LAST_ADR  = ADR_W'(BANK_DEPTH - 1);
    localparam logic [2:0]       LAST_BANK = 3'(NUM_BANKS - 1);
    localparam logic [1:0]       LAT_LAST  = 2'(RD_LAT - 1);

    state_t           state_q, state_d;
    logic [2:0]       bank_q, bank_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [1:0]       lat_q, lat_d;
    logic [7:0]       byte_q, byte_d;
`ifdef SYX_DUMP_CHECKSUM_EN
    logic [6:0]       cks_q, cks_d;
`endif

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        adr_d    = adr_q;
        lat_d    = lat_q;
        byte_d   = byte_q;
`ifdef SYX_DUMP_CHECKSUM_EN
        cks_d    = cks_q;
`endif
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rd_en    = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: if (dump_req) begin
                bank_d  = 3'd0;
                adr_d   = '0;
`ifdef SYX_DUMP_CHECKSUM_EN
                cks_d   = 7'd0;
`endif
                state_d = SOX;
            end
            SOX: begin
                tx_valid = 1'b1;
                tx_data  = 8'hF0;
                if (tx_ready) state_d = MFR;
            end
            MFR: begin
                tx_valid = 1'b1;
                tx_data  = MFR_ID;
                if (tx_ready) state_d = BANK;
            end
            BANK: begin
                tx_valid = 1'b1;
                tx_data  = {5'b0, bank_q};
                if (tx_ready) begin
`ifdef SYX_DUMP_CHECKSUM_EN
                    cks_d = cks_q + {4'b0, bank_q};
`endif
                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                rd_en   = 1'b1;
                lat_d   = 2'd0;
                state_d = RD_WAIT;
            end
            // adr/sel are held here so the bank sees a stable address until capture
            RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    byte_d  = rd_data & 8'h7F;
                    state_d = DATA;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = byte_q;
                if (tx_ready) begin
`ifdef SYX_DUMP_CHECKSUM_EN
                    cks_d = cks_q + byte_q[6:0];
`endif
                    if (adr_q == LAST_ADR) begin
`ifdef SYX_DUMP_CHECKSUM_EN
                        state_d = CKS;
`else
                        state_d = EOX;
`endif
                    end else begin
                        adr_d   = adr_q + 1'b1;
                        state_d = RD_ISSUE;
                    end
                end
            end
`ifdef SYX_DUMP_CHECKSUM_EN
            CKS: begin
                tx_valid = 1'b1;
                tx_data  = {1'b0, -cks_q};
                if (tx_ready) state_d = EOX;
            end
`endif
            EOX: begin
                tx_valid = 1'b1;
                tx_data  = 8'hF7;
                if (tx_ready) state_d = NEXT;
            end
            NEXT: begin
                if (bank_q == LAST_BANK) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    bank_d  = bank_q + 3'd1;
                    adr_d   = '0;
`ifdef SYX_DUMP_CHECKSUM_EN
                    cks_d   = 7'd0;
`endif
                    state_d = SOX;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel = 5'b0;
        if (state_q != IDLE) begin
            case (bank_q)
                3'd0:    sel = 5'b00001;
                3'd1:    sel = 5'b00010;
                3'd2:    sel = 5'b00100;
                3'd3:    sel = 5'b01000;
                3'd4:    sel = 5'b10000;
                default: sel = 5'b00000;
            endcase
        end
    end

    assign bank_adr = bank_q;
    assign adr      = adr_q;
    assign busy     = (state_q != IDLE) && !done;

    always_ff @(posedge CLOCK_25 or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            bank_q  <= 3'd0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            adr_q   <= adr_d;
        end
    end

    // Datapath registers are always loaded before use, so they carry no reset
    always_ff @(posedge CLOCK_25) begin
        lat_q  <= lat_d;
        byte_q <= byte_d;
`ifdef SYX_DUMP_CHECKSUM_EN
        cks_q  <= cks_d;
`endif
    end
endmodule

// File: tb/tb_syx_dump_reader.sv
// Directed bench for syx_dump_reader: full dumps under several data patterns and handshake styles,
// reset abort, ignored re-request, and read-latency timing. Follows SYX_DUMP_CHECKSUM_EN when defined.
`timescale 1ns/1ps
module tb_syx_dump_reader;
    localparam int LAT   = 4;
    localparam int NB    = 5;
    localparam int DEPTH = 64;
`ifdef SYX_DUMP_CHECKSUM_EN
    localparam int MSG_LEN = DEPTH + 5;
    localparam int CKS_CYC = 1;
`else
    localparam int MSG_LEN = DEPTH + 4;
    localparam int CKS_CYC = 0;
`endif
    localparam int BANK_CYC = 3 + DEPTH * (LAT + 2) + CKS_CYC + 2;

    logic       clk = 1'b0;
    logic       rst, dump_req, tx_ready;
    logic [2:0] bank_adr;
    logic [4:0] sel;
    logic [6:0] adr;
    logic       rd_en, tx_valid, busy, done;
    logic [7:0] rd_data, tx_data;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    int done_cnt;
    logic [7:0] got[$];
    int         acc_cyc[$];

    logic [LAT-1:0] pv = '0;
    logic [2:0]     pb[LAT];
    logic [6:0]     pa[LAT];

    syx_dump_reader #(.RD_LAT(LAT)) dut (
        .CLOCK_25(clk), .iRST(rst), .dump_req(dump_req), .bank_adr(bank_adr),
        .sel(sel), .adr(adr), .rd_en(rd_en), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #20 clk = ~clk;

    function automatic logic [7:0] mem(input int m, input logic [2:0] b, input logic [6:0] a);
        if (m == 0) return {1'b0, a};
        if (m == 1) return 8'hFF;
        return 8'(int'(b) * 37 + int'(a) * 11 + 5);
    endfunction

    // Parameter memory: data appears exactly LAT cycles after rd_en, junk otherwise
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], rd_en};
        pb[0] <= bank_adr;
        pa[0] <= adr;
        for (int i = 1; i < LAT; i++) begin
            pb[i] <= pb[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign rd_data = pv[LAT-1] ? mem(mode, pb[LAT-1], pa[LAT-1]) : 8'hA5;

    function automatic logic [7:0] exp_byte(input int m, input int idx);
        int b, p, s;
        b = idx / MSG_LEN;
        p = idx % MSG_LEN;
        if (p == 0) return 8'hF0;
        if (p == 1) return 8'h7D;
        if (p == 2) return 8'(b);
        if (p < 3 + DEPTH) return mem(m, 3'(b), 7'(p - 3)) & 8'h7F;
        if (p == MSG_LEN - 1) return 8'hF7;
        s = b;
        for (int a = 0; a < DEPTH; a++) s += int'(mem(m, 3'(b), 7'(a)) & 8'h7F);
        return 8'((128 - s % 128) % 128);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
        chk({tag, "_tx_data"},  32'(tx_data), 0);
        chk({tag, "_rd_en"},    32'(rd_en), 0);
        chk({tag, "_sel"},      32'(sel), 0);
        chk({tag, "_adr"},      32'(adr), 0);
        chk({tag, "_bank_adr"}, 32'(bank_adr), 0);
        chk({tag, "_busy"},     32'(busy), 0);
        chk({tag, "_done"},     32'(done), 0);
    endtask

    // Runs one complete dump from IDLE; req_again_at re-pulses dump_req at that busy cycle
    task automatic run_dump(input int m, input bit rnd, input int req_again_at);
        bit         prev_stall;
        logic [7:0] prev_data;
        int         n;
        bit         finished;
        mode = m;
        got.delete();
        acc_cyc.delete();
        done_cnt   = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        finished   = 1'b0;
        dump_req   = 1'b1;
        @(posedge clk); #1;
        chk("busy_rise", 32'(busy), 1);
        for (n = 0; n < 20000 && !finished; n++) begin
            dump_req = (n == req_again_at);
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (rd_en) chk("sel_at_rd", 32'(sel), 32'(5'b00001 << bank_adr));
            if (pv[LAT-1]) chk("adr_hold", 32'({bank_adr, adr}), 32'({pb[LAT-1], pa[LAT-1]}));
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                acc_cyc.push_back(n);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 32'(busy), 0);
                if (!rnd) chk("done_cycle", 32'(n), 32'(NB * BANK_CYC - 1));
                finished = 1'b1;
            end
            @(posedge clk); #1;
        end
        dump_req = 1'b0;
        if (!finished) chk("dump_timeout", 0, 1);
        for (int k = 0; k < 12; k++) begin
            if (done) done_cnt++;
            if (busy) chk("busy_after", 32'(busy), 0);
            @(posedge clk); #1;
        end
        chk("done_count", 32'(done_cnt), 1);
        chk("byte_count", 32'(got.size()), 32'(NB * MSG_LEN));
        for (int i = 0; i < got.size(); i++) chk("stream", 32'(got[i]), 32'(exp_byte(m, i)));
    endtask

    initial begin
        int  n;
        bit  hit;
        rst      = 1'b1;
        dump_req = 1'b0;
        tx_ready = 1'b0;
        #50;
        chk_reset_outputs("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_outputs("idle");

        // Data = address, transmitter always ready
        run_dump(0, 1'b0, -1);
        chk("first_sox", 32'(got[0]), 32'hF0);
        chk("first_mfr", 32'(got[1]), 32'h7D);
        chk("bank1_id", 32'(got[MSG_LEN + 2]), 32'h01);
        chk("data_last", 32'(got[3 + 63]), 32'h3F);
        chk("first_data_cyc", 32'(acc_cyc[3]), 32'(LAT + 4));
        chk("data_gap", 32'(acc_cyc[4] - acc_cyc[3]), 32'(LAT + 2));
`ifdef SYX_DUMP_CHECKSUM_EN
        chk("cks_bank0", 32'(got[67]), 32'h20);
        chk("eox_bank0", 32'(got[68]), 32'hF7);
`else
        chk("eox_bank0", 32'(got[67]), 32'hF7);
`endif

        // All-ones memory with a randomly stalling transmitter
        run_dump(1, 1'b1, -1);
        chk("ff_data", 32'(got[3]), 32'h7F);
`ifdef SYX_DUMP_CHECKSUM_EN
        chk("cks_bank2", 32'(got[2 * MSG_LEN + 67]), 32'h3E);
`else
        chk("eox_bank2", 32'(got[2 * MSG_LEN + 67]), 32'hF7);
`endif

        // Mixed pattern with a second dump_req in the middle of the dump
        run_dump(2, 1'b0, 500);

        // Reset during bank 3 data phase
        mode     = 1;
        tx_ready = 1'b1;
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
        hit = 1'b0;
        for (n = 0; n < 5000 && !hit; n++) begin
            if (bank_adr == 3'd3 && tx_valid && adr == 7'd10) hit = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("reach_bank3", 32'(hit), 1);
        #5 rst = 1'b1;
        #1;
        chk_reset_outputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_idle_valid", 32'(tx_valid), 0);
        chk("abort_idle_busy", 32'(busy), 0);

        run_dump(0, 1'b0, -1);
        chk("restart_sox", 32'(got[0]), 32'hF0);
        chk("restart_bank0", 32'(got[2]), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
